// File: rtl/sensor_debounce_multi.sv
// N_CH-channel debouncer for active-low inputs with press/release filters, edge strobes and long-hold flag.
// Optional 2-flop input synchroniser enabled by defining SENSOR_SYNC_EN.
module sensor_debounce_multi #(
    parameter int N_CH          = 4,
    parameter int COUNT_PRESS   = 50000,
    parameter int COUNT_RELEASE = 0,
    parameter int HOLD_CYCLES   = 2500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sensor_in,
    output logic [N_CH-1:0] sensor_out,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] hold_out
);

    localparam int unsigned L_MAX_PR = (COUNT_PRESS > COUNT_RELEASE) ? COUNT_PRESS : COUNT_RELEASE;
    localparam int unsigned L_MAX    = (L_MAX_PR > HOLD_CYCLES) ? L_MAX_PR : HOLD_CYCLES;
    localparam int CW                = $clog2(L_MAX + 1);

    localparam logic [CW-1:0] L_PRESS_LAST = CW'(COUNT_PRESS - 1);
    localparam logic [CW-1:0] L_REL_LAST   = (COUNT_RELEASE > 1) ? CW'(COUNT_RELEASE - 1) : '0;
    localparam logic [CW-1:0] L_HOLD       = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] L_ONE        = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_CHK,
        ST_LOW,
        ST_REL_CHK
    } state_t;

    state_t          r_state    [N_CH];
    state_t          w_state_nx [N_CH];
    logic [CW-1:0]   r_cnt      [N_CH];
    logic [CW-1:0]   w_cnt_nx   [N_CH];
    logic [N_CH-1:0] r_out, w_out_nx;
    logic [N_CH-1:0] r_fall, w_fall_nx;
    logic [N_CH-1:0] r_rise, w_rise_nx;
    logic [N_CH-1:0] r_hold, w_hold_nx;
    logic [N_CH-1:0] w_s;

`ifdef SENSOR_SYNC_EN
    logic [N_CH-1:0] r_sync1, r_sync2;

    // Flops reset to the idle level so reset release never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= sensor_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = sensor_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_out  <= '1;
            r_fall <= '0;
            r_rise <= '0;
            r_hold <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
            r_out  <= w_out_nx;
            r_fall <= w_fall_nx;
            r_rise <= w_rise_nx;
            r_hold <= w_hold_nx;
        end
    end

    always_comb begin
        w_out_nx  = r_out;
        w_fall_nx = '0;
        w_rise_nx = '0;
        w_hold_nx = r_hold;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            case (r_state[i])
                ST_IDLE: begin
                    w_out_nx[i] = 1'b1;
                    if (!w_s[i]) begin
                        if (COUNT_PRESS == 1) begin
                            w_state_nx[i] = ST_LOW;
                            w_out_nx[i]   = 1'b0;
                            w_fall_nx[i]  = 1'b1;
                            w_cnt_nx[i]   = '0;
                        end else begin
                            w_state_nx[i] = ST_PRESS_CHK;
                            w_cnt_nx[i]   = L_ONE;
                        end
                    end
                end
                ST_PRESS_CHK: begin
                    if (w_s[i]) begin
                        w_state_nx[i] = ST_IDLE;
                        w_cnt_nx[i]   = '0;
                    end else if (r_cnt[i] == L_PRESS_LAST) begin
                        w_state_nx[i] = ST_LOW;
                        w_out_nx[i]   = 1'b0;
                        w_fall_nx[i]  = 1'b1;
                        w_cnt_nx[i]   = '0;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + L_ONE;
                    end
                end
                ST_LOW: begin
                    if (w_s[i]) begin
                        if (COUNT_RELEASE <= 1) begin
                            w_state_nx[i] = ST_IDLE;
                            w_out_nx[i]   = 1'b1;
                            w_rise_nx[i]  = 1'b1;
                            w_hold_nx[i]  = 1'b0;
                            w_cnt_nx[i]   = '0;
                        end else begin
                            w_state_nx[i] = ST_REL_CHK;
                            w_cnt_nx[i]   = L_ONE;
                        end
                    end else if (HOLD_CYCLES != 0 && r_cnt[i] != L_HOLD) begin
                        // Counter parks at L_HOLD, so the hold flag stays set without wrapping.
                        w_cnt_nx[i] = r_cnt[i] + L_ONE;
                        if ((r_cnt[i] + L_ONE) == L_HOLD) begin
                            w_hold_nx[i] = 1'b1;
                        end
                    end
                end
                ST_REL_CHK: begin
                    if (!w_s[i]) begin
                        w_state_nx[i] = ST_LOW;
                        w_cnt_nx[i]   = r_hold[i] ? L_HOLD : '0;
                    end else if (r_cnt[i] == L_REL_LAST) begin
                        w_state_nx[i] = ST_IDLE;
                        w_out_nx[i]   = 1'b1;
                        w_rise_nx[i]  = 1'b1;
                        w_hold_nx[i]  = 1'b0;
                        w_cnt_nx[i]   = '0;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] + L_ONE;
                    end
                end
                default: begin
                    w_state_nx[i] = ST_IDLE;
                    w_cnt_nx[i]   = '0;
                end
            endcase
        end
    end

    assign sensor_out = r_out;
    assign fall_pulse = r_fall;
    assign rise_pulse = r_rise;
    assign hold_out   = r_hold;

endmodule

// File: tb/tb_sensor_debounce_multi.sv
// Directed bench for sensor_debounce_multi: N_CH=2, COUNT_PRESS=10, COUNT_RELEASE=3, HOLD_CYCLES=20.
module tb_sensor_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sensor_in;
    logic [1:0] sensor_out;
    logic [1:0] fall_pulse;
    logic [1:0] rise_pulse;
    logic [1:0] hold_out;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_debounce_multi #(
        .N_CH         (2),
        .COUNT_PRESS  (10),
        .COUNT_RELEASE(3),
        .HOLD_CYCLES  (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_in (sensor_in),
        .sensor_out(sensor_out),
        .fall_pulse(fall_pulse),
        .rise_pulse(rise_pulse),
        .hold_out  (hold_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks all four outputs in one go.
    task automatic chk_all(input string tag, input logic [1:0] e_out, input logic [1:0] e_fall,
                           input logic [1:0] e_rise, input logic [1:0] e_hold);
        chk({tag, ".out"},  {6'd0, sensor_out}, {6'd0, e_out});
        chk({tag, ".fall"}, {6'd0, fall_pulse}, {6'd0, e_fall});
        chk({tag, ".rise"}, {6'd0, rise_pulse}, {6'd0, e_rise});
        chk({tag, ".hold"}, {6'd0, hold_out},   {6'd0, e_hold});
    endtask

    initial begin
        // 1. reset state and first press latency
        reset     = 1'b0;
        sensor_in = 2'b00;
        repeat (3) tick();
        chk_all("reset", 2'b11, 2'b00, 2'b00, 2'b00);
        reset     = 1'b1;
        sensor_in = 2'b10;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk_all($sformatf("press_lat%0d", i), (i >= 10) ? 2'b10 : 2'b11,
                    (i == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end
        sensor_in = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all($sformatf("rel_lat%0d", i), (i >= 3) ? 2'b11 : 2'b10,
                    2'b00, (i == 3) ? 2'b01 : 2'b00, 2'b00);
        end

        // 2. glitch rejection: 9 low, 1 high, 9 low, then 10th low falls
        sensor_in = 2'b10;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk_all($sformatf("glitch_a%0d", i), 2'b11, 2'b00, 2'b00, 2'b00);
        end
        sensor_in = 2'b11;
        tick();
        chk_all("glitch_hi", 2'b11, 2'b00, 2'b00, 2'b00);
        sensor_in = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_all($sformatf("glitch_b%0d", i), (i == 10) ? 2'b10 : 2'b11,
                    (i == 10) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end

        // 3. release filter: high 2, low 1, high 3
        sensor_in = 2'b11;
        repeat (2) begin
            tick();
            chk_all("relf_hi2", 2'b10, 2'b00, 2'b00, 2'b00);
        end
        sensor_in = 2'b10;
        tick();
        chk_all("relf_lo1", 2'b10, 2'b00, 2'b00, 2'b00);
        sensor_in = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all($sformatf("relf_hi3_%0d", i), (i >= 3) ? 2'b11 : 2'b10,
                    2'b00, (i == 3) ? 2'b01 : 2'b00, 2'b00);
        end

        // 4. hold on ch1: fall at 10, hold at 30
        sensor_in = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk_all($sformatf("hold%0d", i), (i >= 10) ? 2'b01 : 2'b11,
                    (i == 10) ? 2'b10 : 2'b00, 2'b00, (i >= 30) ? 2'b10 : 2'b00);
        end
        sensor_in = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all($sformatf("hold_rel%0d", i), (i >= 3) ? 2'b11 : 2'b01,
                    2'b00, (i == 3) ? 2'b10 : 2'b00, (i >= 3) ? 2'b00 : 2'b10);
        end

        // 5. independence: ch0 at 0, ch1 4 cycles later; 6. both reach hold
        sensor_in = 2'b10;
        for (int i = 1; i <= 36; i++) begin
            if (i == 5) sensor_in = 2'b00;
            tick();
            chk_all($sformatf("indep%0d", i),
                    {(i < 14) ? 1'b1 : 1'b0, (i < 10) ? 1'b1 : 1'b0},
                    {(i == 14) ? 1'b1 : 1'b0, (i == 10) ? 1'b1 : 1'b0},
                    2'b00,
                    {(i >= 34) ? 1'b1 : 1'b0, (i >= 30) ? 1'b1 : 1'b0});
        end

        // 6. asynchronous reset mid-hold, no rise strobe
        reset = 1'b0;
        #2;
        chk_all("async_rst", 2'b11, 2'b00, 2'b00, 2'b00);
        sensor_in = 2'b11;
        repeat (2) begin
            tick();
            chk_all("rst_held", 2'b11, 2'b00, 2'b00, 2'b00);
        end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_all($sformatf("post_rst%0d", i), 2'b11, 2'b00, 2'b00, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
